// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment patterns are active-high, bit0 = a ... bit6 = g. The same constants
// can drive a hex-to-7-segment encoder so both directions stay in lockstep.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h58;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

    // Result of looking up one segment pattern: hit=0 means illegal pattern.
    typedef struct packed {
        logic       hit;
        logic [3:0] nibble;
    } seg_dec_t;

    // Frame collection state: IDLE while nothing is captured.
    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } scan_state_e;

endpackage : seg_pkg

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to hex nibble lookup.
// Any pattern outside the sixteen legal glyphs returns hit=0, nibble=0.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output seg_dec_t         dec_o
);

    // Pattern lookup against the shared glyph constants.
    always_comb begin
        // NOTE: the output gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        dec_o = '0;
        case (seg_i)
            SEG_HEX_0: dec_o = '{hit: 1'b1, nibble: 4'h0};
            SEG_HEX_1: dec_o = '{hit: 1'b1, nibble: 4'h1};
            SEG_HEX_2: dec_o = '{hit: 1'b1, nibble: 4'h2};
            SEG_HEX_3: dec_o = '{hit: 1'b1, nibble: 4'h3};
            SEG_HEX_4: dec_o = '{hit: 1'b1, nibble: 4'h4};
            SEG_HEX_5: dec_o = '{hit: 1'b1, nibble: 4'h5};
            SEG_HEX_6: dec_o = '{hit: 1'b1, nibble: 4'h6};
            SEG_HEX_7: dec_o = '{hit: 1'b1, nibble: 4'h7};
            SEG_HEX_8: dec_o = '{hit: 1'b1, nibble: 4'h8};
            SEG_HEX_9: dec_o = '{hit: 1'b1, nibble: 4'h9};
            SEG_HEX_A: dec_o = '{hit: 1'b1, nibble: 4'hA};
            SEG_HEX_B: dec_o = '{hit: 1'b1, nibble: 4'hB};
            SEG_HEX_C: dec_o = '{hit: 1'b1, nibble: 4'hC};
            SEG_HEX_D: dec_o = '{hit: 1'b1, nibble: 4'hD};
            SEG_HEX_E: dec_o = '{hit: 1'b1, nibble: 4'hE};
            SEG_HEX_F: dec_o = '{hit: 1'b1, nibble: 4'hF};
            default:   dec_o = '0;
        endcase
    end

endmodule : seg_pattern_decode

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment bus to hex word decoder.
// Samples {seg_in, dig_sel} on sample_en, collects one nibble per digit and
// presents the completed word on a valid/ready interface. Frames that complete
// while the previous word is still unaccepted are dropped with an overrun pulse.
// Optional build macro: SEG_STABLE_FILTER_EN -- a sample is accepted only after
// STABLE_CYCLES identical consecutive sample_en cycles, once per stable run.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    sample_en,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    bad_pattern,
    output logic                    overrun
);

    if (NUM_DIGITS < 1) begin : g_bad_digits
        $error("NUM_DIGITS must be at least 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end

    logic accept;

`ifdef SEG_STABLE_FILTER_EN
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SEG_W+NUM_DIGITS-1:0] last_q;
    logic [CNT_W-1:0]            run_q, run_d;
    logic                        continuing;

    // Run length of identical qualified samples; accept when it first reaches CNT_MAX.
    always_comb begin
        continuing = sample_en && ({seg_in, dig_sel} == last_q) && (run_q != '0);
        run_d      = '0;
        if (sample_en) begin
            if (!continuing) begin
                run_d = CNT_W'(1);
            end else if (run_q == CNT_MAX) begin
                run_d = CNT_MAX;
            end else begin
                run_d = run_q + CNT_W'(1);
            end
        end
        accept = (run_d == CNT_MAX) && !(continuing && (run_q == CNT_MAX));
    end

    // Filter history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= '0;
        end else begin
            run_q  <= run_d;
            last_q <= {seg_in, dig_sel};
        end
    end
`else
    assign accept = sample_en;
`endif

    seg_dec_t dec;

    seg_pattern_decode u_decode (
        .seg_i (seg_in),
        .dec_o (dec)
    );

    scan_state_e               state_q, state_d;
    logic [NUM_DIGITS-1:0]     captured_q, captured_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic                      frame_err_q, frame_err_d;
    logic [4*NUM_DIGITS-1:0]   word_q, word_d;
    logic                      valid_q, valid_d;
    logic                      bad_q, bad_d;
    logic                      overrun_q, overrun_d;
    logic                      sel_one_hot, sel_multi_hot;
    logic                      frame_done;

    assign sel_one_hot   = (dig_sel != '0) &&
                           ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    assign sel_multi_hot = (dig_sel != '0) && !sel_one_hot;

    // Next-state: nibble capture, error tracking, frame FSM and output handoff.
    always_comb begin
        state_d     = state_q;
        captured_d  = captured_q;
        shadow_d    = shadow_q;
        frame_err_d = frame_err_q;
        word_d      = word_q;
        valid_d     = valid_q;
        bad_d       = bad_q;
        overrun_d   = 1'b0;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (sel_one_hot) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (dig_sel[i]) begin
                        shadow_d[4*i +: 4] = dec.hit ? dec.nibble : 4'h0;
                    end
                end
                captured_d = captured_q | dig_sel;
                if (!dec.hit) begin
                    frame_err_d = 1'b1;
                end
            end else if (sel_multi_hot) begin
                frame_err_d = 1'b1;
            end
        end

        // The completing sample is included via captured_d.
        frame_done = accept && sel_one_hot && (&captured_d);

        case (state_q)
            ST_IDLE:    if (accept && sel_one_hot && !frame_done) state_d = ST_COLLECT;
            ST_COLLECT: if (frame_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (frame_done) begin
            if (!valid_q || word_ready) begin
                word_d  = shadow_d;
                valid_d = 1'b1;
                bad_d   = frame_err_d;
            end else begin
                overrun_d = 1'b1;
            end
            captured_d  = '0;
            frame_err_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            captured_q  <= '0;
            // NOTE: the shadow nibbles are reset as well, so a partial frame
            // never carries stale data across a reset.
            shadow_q    <= '0;
            frame_err_q <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            bad_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q     <= state_d;
            captured_q  <= captured_d;
            shadow_q    <= shadow_d;
            frame_err_q <= frame_err_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            bad_q       <= bad_d;
            overrun_q   <= overrun_d;
        end
    end

    assign word_out    = word_q;
    assign word_valid  = valid_q;
    assign bad_pattern = bad_q;
    assign overrun     = overrun_q;

endmodule : seg_scan_decoder

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder with a behavioural frame model.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int ST = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel;
    logic            sample_en;
    logic [4*ND-1:0] word_out;
    logic            word_valid;
    logic            word_ready;
    logic            bad_pattern;
    logic            overrun;

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .sample_en   (sample_en),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .bad_pattern (bad_pattern),
        .overrun     (overrun)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    int              m_nib [ND];
    bit              m_have [ND];
    bit              m_err;
    bit              m_valid;
    logic [4*ND-1:0] m_word;
    bit              m_bad;
    bit              m_ovr;
    int              m_run;
    logic [6:0]      m_last_seg;
    logic [ND-1:0]   m_last_sel;
    bit              m_last_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_nib[i]  = 0;
            m_have[i] = 1'b0;
        end
        m_err = 0; m_valid = 0; m_word = '0; m_bad = 0; m_ovr = 0;
        m_run = 0; m_last_seg = '0; m_last_sel = '0; m_last_ok = 0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_edge();
        bit acc, done, all;
        int pc, idx, hex;
`ifdef SEG_STABLE_FILTER_EN
        if (sample_en) begin
            if (m_last_ok && seg_in == m_last_seg && dig_sel == m_last_sel) m_run++;
            else m_run = 1;
            m_last_seg = seg_in; m_last_sel = dig_sel; m_last_ok = 1;
        end else begin
            m_run = 0; m_last_ok = 0;
        end
        acc = (m_run == ST);
`else
        acc = sample_en;
`endif
        m_ovr = 0;
        done  = 0;
        if (acc) begin
            pc = 0; idx = 0;
            for (int i = 0; i < ND; i++) if (dig_sel[i]) begin pc++; idx = i; end
            if (pc == 1) begin
                hex = -1;
                for (int h = 0; h < 16; h++) if (tab[h] == seg_in) hex = h;
                if (hex < 0) begin m_nib[idx] = 0; m_err = 1; end
                else m_nib[idx] = hex;
                m_have[idx] = 1;
                all = 1;
                for (int i = 0; i < ND; i++) if (!m_have[i]) all = 0;
                done = all;
            end else if (pc > 1) begin
                m_err = 1;
            end
        end
        if (done) begin
            if (!m_valid || word_ready) begin
                m_word = '0;
                for (int i = 0; i < ND; i++) m_word = m_word | ((4*ND)'(m_nib[i]) << (4*i));
                m_valid = 1;
                m_bad   = m_err;
            end else begin
                m_ovr = 1;
            end
            for (int i = 0; i < ND; i++) m_have[i] = 0;
            m_err = 0;
        end else if (m_valid && word_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid", 32'(word_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) begin
            check("word", 32'(word_out), 32'(m_word));
            check("bad", 32'(bad_pattern), 32'(m_bad));
        end
    endtask

    // One clock: drive, edge, update model, compare 1 time unit later.
    task automatic tick(input logic [6:0] s, input logic [ND-1:0] d, input logic en, input logic rdy);
        seg_in = s; dig_sel = d; sample_en = en; word_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // One accepted sample; the last tick is the accepting edge.
    task automatic samp(input logic [6:0] s, input logic [ND-1:0] d);
`ifdef SEG_STABLE_FILTER_EN
        tick(7'h00, '0, 1'b0, word_ready);
        repeat (ST) tick(s, d, 1'b1, word_ready);
`else
        tick(s, d, 1'b1, word_ready);
`endif
    endtask

    task automatic frame(input logic [15:0] w);
        logic [15:0] v;
        v = w;
        for (int i = 0; i < ND; i++) samp(tab[int'((v >> (4*i)) & 16'hF)], ND'(1) << i);
    endtask

    initial begin
        logic [6:0]    rs;
        logic [ND-1:0] rd;
        logic          re, rr;

        rst_n = 1'b0; seg_in = '0; dig_sel = '0; sample_en = 1'b0; word_ready = 1'b1;
        model_reset();
        #2;
        check("rst_word", 32'(word_out), 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_bad", 32'(bad_pattern), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean frame 3210 with ready high.
        word_ready = 1'b1;
        frame(16'h3210);
        check("t1_valid", 32'(word_valid), 32'h1);
        check("t1_word", 32'(word_out), 32'h3210);
        check("t1_bad", 32'(bad_pattern), 32'h0);
        tick(7'h00, '0, 1'b0, 1'b1);
        check("t1_drop", 32'(word_valid), 32'h0);

        // Illegal pattern in digit 2.
        samp(7'h71, 4'b0001); samp(7'h58, 4'b0010); samp(7'h00, 4'b0100); samp(7'h77, 4'b1000);
        check("t2_word", 32'(word_out), 32'hA0CF);
        check("t2_bad", 32'(bad_pattern), 32'h1);
        frame(16'h3210);
        check("t2_clean_bad", 32'(bad_pattern), 32'h0);

        // Overrun while consumer stalls.
        tick(7'h00, '0, 1'b0, 1'b1);
        word_ready = 1'b0;
        frame(16'h3210);
        check("t3_valid", 32'(word_valid), 32'h1);
        frame(16'hFFFF);
        check("t3_ovr", 32'(overrun), 32'h1);
        check("t3_hold", 32'(word_out), 32'h3210);
        tick(7'h00, '0, 1'b0, 1'b0);
        check("t3_ovr_pulse", 32'(overrun), 32'h0);
        tick(7'h00, '0, 1'b0, 1'b1);
        check("t3_handshake", 32'(word_valid), 32'h0);

        // Multi-hot select and empty select inside a frame.
        word_ready = 1'b1;
        samp(7'h3F, 4'b0001);
        samp(7'h06, 4'b0011);
        samp(7'h7F, 4'b0000);
        samp(7'h06, 4'b0010); samp(7'h5B, 4'b0100); samp(7'h4F, 4'b1000);
        check("t4_word", 32'(word_out), 32'h3210);
        check("t4_bad", 32'(bad_pattern), 32'h1);

        // Reset mid-frame.
        tick(7'h00, '0, 1'b0, 1'b1);
        word_ready = 1'b0;
        frame(16'h5A5A);
        samp(7'h3F, 4'b0001); samp(7'h06, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(word_valid), 32'h0);
        check("t5_rst_word", 32'(word_out), 32'h0);
        check("t5_rst_bad", 32'(bad_pattern), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        word_ready = 1'b1;
        samp(7'h5B, 4'b0100); samp(7'h4F, 4'b1000);
        check("t5_partial", 32'(word_valid), 32'h0);
        samp(7'h3F, 4'b0001); samp(7'h06, 4'b0010);
        check("t5_complete", 32'(word_valid), 32'h1);
        check("t5_word", 32'(word_out), 32'h3210);

`ifdef SEG_STABLE_FILTER_EN
        // Filter: short run rejected, full run accepted once.
        tick(7'h00, '0, 1'b0, 1'b1);
        repeat (2) tick(7'h3F, 4'b0001, 1'b1, 1'b1);
        repeat (3) tick(7'h06, 4'b0010, 1'b1, 1'b1);
        repeat (3) tick(7'h5B, 4'b0100, 1'b1, 1'b1);
        repeat (3) tick(7'h4F, 4'b1000, 1'b1, 1'b1);
        check("f_short", 32'(word_valid), 32'h0);
        repeat (3) tick(7'h3F, 4'b0001, 1'b1, 1'b1);
        check("f_accept", 32'(word_valid), 32'h1);
        check("f_word", 32'(word_out), 32'h3210);
        repeat (7) tick(7'h3F, 4'b0001, 1'b1, 1'b1);
        tick(7'h00, '0, 1'b0, 1'b1);
        samp(7'h3F, 4'b0001); samp(7'h06, 4'b0010); samp(7'h5B, 4'b0100);
        repeat (10) tick(7'h4F, 4'b1000, 1'b1, 1'b1);
        samp(7'h3F, 4'b0001); samp(7'h06, 4'b0010); samp(7'h5B, 4'b0100);
        check("f_once", 32'(word_valid), 32'h0);
`endif

        // Randomised traffic, each value held for a random number of cycles.
        repeat (250) begin
            re = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       rd = '0;
                1:       rd = ND'($urandom);
                default: rd = ND'(1) << $urandom_range(0, ND - 1);
            endcase
            if ($urandom_range(0, 7) == 0) rs = 7'($urandom);
            else rs = tab[$urandom_range(0, 15)];
            rr = ($urandom_range(0, 2) != 0);
            repeat ($urandom_range(1, 4)) tick(rs, rd, re, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan_decoder

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reverse path of the hex-to-7-segment encoding: samples a multiplexed 7-segment display bus (segment pattern plus one-hot digit select) and rebuilds the hex word shown.
- Used for on-chip display loopback and self-check of the AES result display.
- Collects one nibble per digit and presents the word on a valid/ready output with error and overrun flags.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits, which is also the number of nibbles in the word.
- STABLE_CYCLES, 3, consecutive identical samples required before a sample is accepted; used only when SEG_STABLE_FILTER_EN is defined.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment pattern, active-high; bit0=a … bit6=g.
- dig_sel  in  NUM_DIGITS  digit enable; bit i selects digit i (nibble i, LSB = digit 0).
- sample_en  in  1  bus sample qualifier.
- word_out  out  4*NUM_DIGITS  decoded word.
- word_valid  out  1  word_out is valid.
- word_ready  in  1  consumer accepts the word.
- bad_pattern  out  1  the presented word contained an illegal pattern or a multi-hot select; valid only while word_valid=1.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: word_out=0, word_valid=0, bad_pattern=0, overrun=0.
  - Internal: captured mask=0, shadow nibbles=0, frame_err=0, FSM=IDLE.
- Decode table (hex→pattern):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, B:7C, C:58, D:5E, E:79, F:71
  - Any other pattern is illegal.
- Accepted sample: clk edge with sample_en=1 (and, if enabled, the filter qualifies it).
  - dig_sel exactly one-hot, index i:
    - shadow[i] = decoded nibble.
    - If the pattern is illegal: shadow[i] = 0 and frame_err is set.
    - captured[i] is set.
    - Re-sampling an already-captured digit overwrites it (latest wins), no error.
  - dig_sel = 0: sample ignored, no flag.
  - dig_sel multi-hot: no nibble written, frame_err is set.
- FSM:
  - IDLE (captured=0) → COLLECT on the first accepted one-hot sample.
  - COLLECT → IDLE in the cycle the captured mask becomes all-ones, including the current sample. That is the frame completion.
- Frame completion (output side, independent valid flag):
  - Output free (word_valid=0, or word_valid&&word_ready in the same cycle):
    - On the next edge: word_out = shadow (with the final nibble included).
    - word_valid=1, bad_pattern = frame_err (including the current sample).
    - captured and frame_err are cleared.
    - Latency: one cycle from the completing sample edge to word_valid.
  - Output busy (word_valid=1, word_ready=0):
    - Frame dropped; overrun pulses for one cycle.
    - word_out and bad_pattern are unchanged; captured and frame_err are cleared.
- word_valid falls the cycle after word_valid&&word_ready unless a new frame loads in that same edge.
- word_out is stable while word_valid=1 and word_ready=0.
- Reset mid-frame discards partial nibbles; the next frame needs all NUM_DIGITS digits.

Optional Feature:
- SEG_STABLE_FILTER_EN defined:
  - A sample is accepted only after {seg_in, dig_sel} is identical on STABLE_CYCLES consecutive clocks with sample_en=1.
  - One acceptance per stable run; the filter re-arms when the value changes or sample_en drops.
  - The counter saturates.
  - Latency grows by STABLE_CYCLES-1 cycles.
- SEG_STABLE_FILTER_EN undefined: every sample_en=1 cycle is a sample; no filter logic.

Decomposition:
- Package seg_pkg:
  - SEG_HEX_0 … SEG_HEX_F 7-bit constants.
  - SEG_W=7.
  - seg_dec_t struct {hit, nibble[3:0]}.
  - The encoder can share the same constants.
- Sub-module seg_pattern_decode: combinational 7-bit → seg_dec_t lookup from the package constants; instantiated once.
- Stable filter and FSM stay in the top level.

Test Plan (NUM_DIGITS=4, filter off unless noted):
- Samples d0=3F, d1=06, d2=5B, d3=4F with word_ready=1 → one cycle after the d3 edge: word_out=16'h3210, word_valid=1 for one cycle, bad_pattern=0.
- Frame d0=71, d1=58, d2=00, d3=77 → word_out=16'hA0CF, bad_pattern=1; the next clean frame gives bad_pattern=0.
- word_ready=0, frame 16'h3210 presented, second frame 16'hFFFF completes → overrun one-cycle pulse, word_out stays 16'h3210. Then word_ready=1 → handshake, word_valid drops next cycle.
- dig_sel=4'b0011 sample inside an otherwise clean frame → no nibble written, bad_pattern=1 on completion. dig_sel=0 sample → no effect.
- d0, d1 captured, rst_n pulsed low mid-cycle → outputs zero immediately. After release, d2 and d3 alone do not complete a frame; all four are required.
- SEG_STABLE_FILTER_EN, STABLE_CYCLES=3:
  - d0=3F held 2 cycles then changed → not accepted.
  - Held 3 cycles → accepted once.
  - Held 10 cycles → still accepted only once.
